// File: rtl/wrr_burst_arbiter.sv
// N-way weighted round-robin arbiter with burst locking: a winner holds the grant until its
// req_last beat and may win up to weight[i] consecutive bursts. Optional: WRR_BURST_TIMEOUT_EN.
module wrr_burst_arbiter #(
  parameter int unsigned REQUEST_LINES = 4,
  parameter int unsigned WEIGHT_W      = 4
`ifdef WRR_BURST_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC   = 64
`endif
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic [REQUEST_LINES-1:0]            req,
  input  logic [REQUEST_LINES-1:0]            req_last,
  input  logic [REQUEST_LINES*WEIGHT_W-1:0]   weight,
  output logic [REQUEST_LINES-1:0]            grant,
  output logic [$clog2(REQUEST_LINES)-1:0]    grant_idx,
  output logic                                grant_valid
`ifdef WRR_BURST_TIMEOUT_EN
  ,
  output logic                                timeout_pulse
`endif
);

  localparam int unsigned N    = REQUEST_LINES;
  localparam int unsigned IdxW = $clog2(REQUEST_LINES);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e              r_state;
  logic [N-1:0]        r_grant;
  logic [IdxW-1:0]     r_idx;
  logic [IdxW-1:0]     r_ptr;
  logic                r_valid;
  logic [WEIGHT_W-1:0] r_credit [N];

  logic [IdxW-1:0]     w_ptr_next;
  logic [IdxW-1:0]     w_arb_ptr;
  logic [N-1:0]        w_arb_req;
  logic [2*N-1:0]      w_ptr_oh;
  logic [2*N-1:0]      w_dbl;
  logic [2*N-1:0]      w_gnt_dbl;
  logic [N-1:0]        w_win;
  logic [IdxW-1:0]     w_win_idx;
  logic [WEIGHT_W-1:0] w_win_wt;
  logic [WEIGHT_W-1:0] w_win_load;
  logic                w_hold_req;
  logic                w_hold_last;
  logic [WEIGHT_W-1:0] w_hold_credit;
  logic                w_timeout;
  logic                w_busy_end;
  logic                w_busy_again;

`ifdef WRR_BURST_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
  logic [CntW-1:0] r_tcnt;
  logic            r_tpulse;
  assign w_timeout     = (r_state == StBusy) && (r_tcnt == CntW'(TIMEOUT_CYC - 1));
  assign timeout_pulse = r_tpulse;
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_ptr_next = (r_idx == IdxW'(N - 1)) ? '0 : r_idx + 1'b1;
    // While busy, arbitrate as if the holder has already rotated away.
    w_arb_ptr  = (r_state == StBusy) ? w_ptr_next : r_ptr;
    w_arb_req  = (r_state == StBusy) ? (req & ~r_grant) : req;
    w_ptr_oh   = '0;
    w_ptr_oh[w_arb_ptr] = 1'b1;
    // First set bit at or above the pointer; the upper copy supplies the wrap-around.
    w_dbl      = {w_arb_req, w_arb_req};
    w_gnt_dbl  = w_dbl & ~(w_dbl - w_ptr_oh);
    w_win      = w_gnt_dbl[N-1:0] | w_gnt_dbl[2*N-1:N];
    w_win_idx  = '0;
    for (int k = 0; k < N; k++) begin
      if (w_win[k]) w_win_idx = IdxW'(k);
    end
    w_win_wt   = weight[w_win_idx*WEIGHT_W +: WEIGHT_W];
    w_win_load = (w_win_wt == '0) ? '0 : w_win_wt - 1'b1;

    w_hold_req    = req[r_idx];
    w_hold_last   = req_last[r_idx];
    w_hold_credit = r_credit[r_idx];
    w_busy_end    = (r_state == StBusy) &&
                    (!w_hold_req || (w_hold_last && (w_hold_credit == '0)) || w_timeout);
    w_busy_again  = (r_state == StBusy) && w_hold_req && w_hold_last &&
                    (w_hold_credit != '0) && !w_timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
      r_valid <= 1'b0;
      for (int k = 0; k < N; k++) r_credit[k] <= '0;
`ifdef WRR_BURST_TIMEOUT_EN
      r_tcnt   <= '0;
      r_tpulse <= 1'b0;
`endif
    end else begin
`ifdef WRR_BURST_TIMEOUT_EN
      r_tpulse <= 1'b0;
`endif
      if (en) begin
        unique case (r_state)
          StIdle: begin
            if (|w_win) begin
              r_state <= StBusy;
              r_grant <= w_win;
              r_idx   <= w_win_idx;
              r_valid <= 1'b1;
              if (r_credit[w_win_idx] == '0) r_credit[w_win_idx] <= w_win_load;
            end
`ifdef WRR_BURST_TIMEOUT_EN
            r_tcnt <= '0;
`endif
          end
          StBusy: begin
            if (w_busy_end) begin
              r_ptr           <= w_ptr_next;
              r_credit[r_idx] <= '0;
              if (|w_win) begin
                r_grant <= w_win;
                r_idx   <= w_win_idx;
                r_valid <= 1'b1;
                if (r_credit[w_win_idx] == '0) r_credit[w_win_idx] <= w_win_load;
              end else begin
                r_state <= StIdle;
                r_grant <= '0;
                r_idx   <= '0;
                r_valid <= 1'b0;
              end
            end else if (w_busy_again) begin
              r_credit[r_idx] <= w_hold_credit - 1'b1;
            end
`ifdef WRR_BURST_TIMEOUT_EN
            r_tcnt   <= w_busy_end ? '0 : r_tcnt + 1'b1;
            r_tpulse <= w_timeout;
`endif
          end
          default: r_state <= StIdle;
        endcase
      end
    end
  end

  assign grant       = r_grant;
  assign grant_idx   = r_idx;
  assign grant_valid = r_valid;

endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// Directed bench for wrr_burst_arbiter: each step queues the expected grant for the next cycle
// and the queued value is popped and checked one clock later.
module tb_wrr_burst_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  req;
  logic [3:0]  req_last;
  logic [15:0] weight;
  logic [3:0]  grant;
  logic [1:0]  grant_idx;
  logic        grant_valid;
`ifdef WRR_BURST_TIMEOUT_EN
  logic        timeout_pulse;
`endif

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q [$];

  always #5 clk = ~clk;

  wrr_burst_arbiter #(
    .REQUEST_LINES(4),
    .WEIGHT_W     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .req_last   (req_last),
    .weight     (weight),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
`ifdef WRR_BURST_TIMEOUT_EN
    ,
    .timeout_pulse(timeout_pulse)
`endif
  );

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 0; k < 4; k++) if (g[k]) r = 2'(k);
    return r;
  endfunction

  task automatic step(input string tag, input logic i_en, input logic [3:0] i_req,
                      input logic [3:0] i_last, input logic [3:0] exp_g);
    logic [3:0] e;
    en       = i_en;
    req      = i_req;
    req_last = i_last;
    exp_q.push_back(exp_g);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    total++;
    assert (grant === e) else begin
      bad++;
      $error("FAIL %s grant observed=%b expected=%b", tag, grant, e);
    end
    total++;
    assert (grant_idx === idx_of(e)) else begin
      bad++;
      $error("FAIL %s grant_idx observed=%0d expected=%0d", tag, grant_idx, idx_of(e));
    end
    total++;
    assert (grant_valid === (|e)) else begin
      bad++;
      $error("FAIL %s grant_valid observed=%b expected=%b", tag, grant_valid, |e);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; req = '0; req_last = '0; weight = 16'h1111;
    step("reset0", 1'b1, 4'b1010, 4'b0000, 4'b0000);
    step("reset1", 1'b1, 4'b1010, 4'b1111, 4'b0000);
    rst = 1'b0;
    step("idle_en0", 1'b0, 4'b1010, 4'b0000, 4'b0000);

    // Equal weights, 3-beat bursts on lines 1 and 3.
    step("t1_win1",  1'b1, 4'b1010, 4'b0000, 4'b0010);
    step("t1_b1",    1'b1, 4'b1010, 4'b0000, 4'b0010);
    step("t1_b2",    1'b1, 4'b1010, 4'b0000, 4'b0010);
    step("t1_end1",  1'b1, 4'b1010, 4'b0010, 4'b1000);
    step("t1_b4",    1'b1, 4'b1010, 4'b0000, 4'b1000);
    step("t1_b5",    1'b1, 4'b1010, 4'b0000, 4'b1000);
    step("t1_wrap",  1'b1, 4'b1010, 4'b1000, 4'b0010);
    step("t1_abort", 1'b1, 4'b0000, 4'b0000, 4'b0000);

    // weight[0]=3, weight[1]=1, 2-beat bursts; last on the idle line is ignored.
    weight = 16'h0013;
    step("t2_win0", 1'b1, 4'b0011, 4'b0000, 4'b0001);
    for (int r = 0; r < 2; r++) begin
      step("t2_b1a", 1'b1, 4'b0011, 4'b0000, 4'b0001);
      step("t2_b1b", 1'b1, 4'b0011, 4'b0011, 4'b0001);
      step("t2_b2a", 1'b1, 4'b0011, 4'b0000, 4'b0001);
      step("t2_b2b", 1'b1, 4'b0011, 4'b0011, 4'b0001);
      step("t2_b3a", 1'b1, 4'b0011, 4'b0000, 4'b0001);
      step("t2_b3b", 1'b1, 4'b0011, 4'b0011, 4'b0010);
      step("t2_b4a", 1'b1, 4'b0011, 4'b0000, 4'b0010);
      step("t2_b4b", 1'b1, 4'b0011, 4'b0011, 4'b0001);
    end
    step("t2_drop", 1'b1, 4'b0000, 4'b0000, 4'b0000);

    // Abort on line 2 rotates the pointer to 3 with no bubble.
    weight = 16'h1111;
    step("t3_win2",   1'b1, 4'b1100, 4'b0000, 4'b0100);
    step("t3_beat",   1'b1, 4'b1100, 4'b0000, 4'b0100);
    step("t3_abort",  1'b1, 4'b1010, 4'b0000, 4'b1000);
    step("t3_end3",   1'b1, 4'b1010, 4'b1000, 4'b0010);
    step("t3_idle",   1'b1, 4'b0000, 4'b0000, 4'b0000);

    // en=0 freezes the burst even with last pulsed on the holder.
    step("t4_win0", 1'b1, 4'b0011, 4'b0000, 4'b0001);
    step("t4_beat", 1'b1, 4'b0011, 4'b0000, 4'b0001);
    for (int c = 0; c < 5; c++) begin
      step("t4_frozen", 1'b0, 4'b0011, (c % 2 == 0) ? 4'b0001 : 4'b0000, 4'b0001);
    end
    step("t4_nolast", 1'b1, 4'b0011, 4'b0000, 4'b0001);
    step("t4_end0",   1'b1, 4'b0011, 4'b0001, 4'b0010);
    step("t4_end1",   1'b1, 4'b0011, 4'b0010, 4'b0001);
    step("t4_idle",   1'b1, 4'b0000, 4'b0000, 4'b0000);

    // weight[1]=0 acts as 1: lines 1 and 2 alternate on single-beat bursts.
    weight = 16'h1101;
    step("t5_win1", 1'b1, 4'b0110, 4'b0110, 4'b0010);
    step("t5_alt2", 1'b1, 4'b0110, 4'b0110, 4'b0100);
    step("t5_alt1", 1'b1, 4'b0110, 4'b0110, 4'b0010);
    step("t5_alt2", 1'b1, 4'b0110, 4'b0110, 4'b0100);
    step("t5_alt1", 1'b1, 4'b0110, 4'b0110, 4'b0010);
    step("t5_mid",  1'b1, 4'b0110, 4'b0000, 4'b0010);
    rst = 1'b1;
    step("t5_rst",  1'b1, 4'b0110, 4'b0000, 4'b0000);
    rst = 1'b0;
    step("t5_post", 1'b1, 4'b0000, 4'b0000, 4'b0000);
    step("t5_ptr0", 1'b1, 4'b1100, 4'b0000, 4'b0100);
    step("t5_done", 1'b1, 4'b0000, 4'b0000, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
